param_cpu_core: RTL and testbench
=================================

PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 SHALL expose parameter DATA_W, default 16, register/data width (>=16).
REQ-002 SHALL expose parameter ADDR_W, default 5, memory address and PC width (1..16).
REQ-003 SHALL expose parameter NUM_REGS, default 8, register count (2..8, index = field mod NUM_REGS).
REQ-004 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_execution  input  1  level enable for launching new fetches.
REQ-007 SHALL have port mem_ready  input  1  memory completes current request this cycle.
REQ-008 SHALL have port mem_read_data  input  DATA_W  read data, valid when mem_ready=1; instruction in bits [15:0].
REQ-009 SHALL have ports mem_addr  output  ADDR_W; mem_write_data  output  DATA_W; mem_req  output  1; mem_write  output  1 (write qualifier of mem_req).
REQ-010 SHALL have ports alu_out  output  DATA_W; pc  output  ADDR_W; retired  output  1 (one-cycle pulse per completed instruction); halted  output  1.

Function
REQ-011 Instruction fields: opcode[15:11], rd[10:8], rs[7:5], imm[7:0], shift[4:1]; opcode values per shared package (HALT, MV, NOT, AND, OR, XOR, ADD, SUB, COMP, ANDI, ADDI, SRI, SLI, LUI, LI, BEQ, BNE, LOAD, STORE).
REQ-012 FSM states: FETCH, FETCH_WAIT, EXECUTE, WRITE_BACK, MEM_WAIT, NEXT, HALT.
REQ-013 FETCH: if start_execution=1, drive mem_addr=pc, mem_req=1, mem_write=0 -> FETCH_WAIT; else hold.
REQ-014 Handshake: mem_req, mem_addr, mem_write, mem_write_data SHALL stay stable until the cycle mem_ready=1; mem_req drops the following cycle.
REQ-015 FETCH_WAIT: on mem_ready latch mem_read_data[15:0] as instruction -> EXECUTE; else wait indefinitely.
REQ-016 ALU ops (NOT/AND/OR/XOR/ADD/SUB/COMP): EXECUTE registers alu_out -> WRITE_BACK writes rd -> NEXT; results modulo 2^DATA_W; COMP yields 1 if equal else 0.
REQ-017 MV, ANDI, ADDI, SRI, SLI, LUI, LI: single EXECUTE cycle writes rd -> NEXT; imm zero-extended; LUI writes imm to bits [DATA_W-1:DATA_W-8], zeros elsewhere; LI replaces bits [7:0] only; shifts logical by shift (0..15).
REQ-018 BEQ/BNE: taken when rd[0]=1 / rd[0]=0; taken -> pc <= pc - sext(imm[6:0]) mod 2^ADDR_W; not taken -> pc <= pc+1; both -> FETCH, retired pulses.
REQ-019 LOAD: mem_addr = (rs + shift)[ADDR_W-1:0], read request -> MEM_WAIT; on mem_ready write mem_read_data to rd -> NEXT.
REQ-020 STORE: mem_addr = rs[ADDR_W-1:0], mem_write_data = rd, mem_write=1 -> MEM_WAIT; on mem_ready -> NEXT, no register write.
REQ-021 NEXT: pc <= pc+1 (wraps 2^ADDR_W-1 -> 0), retired=1 for that cycle -> FETCH.
REQ-022 HALT opcode: halted=1 -> HALT state, sticky until reset; no retired pulse, pc unchanged, no further memory requests.
REQ-023 Undefined opcode SHALL execute as NOP (-> NEXT).
REQ-024 start_execution=0 SHALL NOT abort an in-flight instruction; it only blocks the next FETCH launch.
REQ-025 Same-cycle read/write of a register SHALL read the old value (register file updates on clock edge).

Reset
REQ-026 reset=1 at a clock edge SHALL set pc=0, all registers=0, alu_out=0, mem_req=0, mem_write=0, mem_addr=0, mem_write_data=0, retired=0, halted=0, state=FETCH, overriding any state incl. MEM_WAIT mid-handshake.
REQ-027 An outstanding memory request SHALL be abandoned on reset; a late mem_ready SHALL be ignored.

Structure
REQ-028 Opcode encodings, field positions and FSM state encoding SHALL live in shared package cpu_pkg.
REQ-029 Combinational ALU SHALL be sub-module cpu_alu (op, a, b, shift -> result, DATA_W parametrised).

Verification
REQ-030 LI r1,5; LI r2,3; ADD r1,r2; HALT, mem_ready always 1 -> r1=8, retired pulses 3, halted=1, pc=3.
REQ-031 Fetch with mem_ready delayed 4 cycles -> mem_req and mem_addr held constant 4 cycles, single instruction executed.
REQ-032 DATA_W=32: LUI r0,0xAB -> r0=0xAB000000; ADDI r0,0xFF -> 0xAB0000FF; SUB from 0 minus 1 -> 0xFFFFFFFF.
REQ-033 COMP equal (r3=r4=7) then BEQ r3 imm=2 at pc=6 -> pc=4; BNE not taken -> pc=7.
REQ-034 STORE r1->addr 9, LOAD r2 from r0=5 shift=4 -> write seen at addr 9, r2 equals stored value; reset asserted during MEM_WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for param_cpu_core: instruction field positions, opcode
// encodings, controller state encoding and small opcode-class helpers.
package cpu_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 1;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [4:0] {
    OP_HALT  = 5'd0,
    OP_MV    = 5'd1,
    OP_NOT   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_ADD   = 5'd6,
    OP_SUB   = 5'd7,
    OP_COMP  = 5'd8,
    OP_ANDI  = 5'd9,
    OP_ADDI  = 5'd10,
    OP_SRI   = 5'd11,
    OP_SLI   = 5'd12,
    OP_LUI   = 5'd13,
    OP_LI    = 5'd14,
    OP_BEQ   = 5'd15,
    OP_BNE   = 5'd16,
    OP_LOAD  = 5'd17,
    OP_STORE = 5'd18
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_EXECUTE,
    S_WRITE_BACK,
    S_MEM_WAIT,
    S_NEXT,
    S_HALT
  } state_t;

  // Register-register ops go through a registered alu_out before write-back.
  function automatic logic is_alu_op(input opcode_t op);
    return op inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_COMP};
  endfunction

  function automatic logic is_single_op(input opcode_t op);
    return op inside {OP_MV, OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LUI, OP_LI};
  endfunction

  function automatic logic uses_imm(input opcode_t op);
    return op inside {OP_ANDI, OP_ADDI, OP_LUI, OP_LI};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: a is the rd operand, b is rs or the zero-extended
// immediate, shift is the 4-bit logical shift amount.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        shift,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_MV:           result = b;
      OP_NOT:          result = ~b;
      OP_AND, OP_ANDI: result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB:          result = a - b;
      OP_COMP:         result = (a == b) ? DATA_W'(1) : '0;
      OP_SRI:          result = a >> shift;
      OP_SLI:          result = a << shift;
      OP_LUI:          result = {b[7:0], {(DATA_W-8){1'b0}}};
      OP_LI:           result = {a[DATA_W-1:8], b[7:0]};
      default:         result = a;
    endcase
  end

endmodule

// File: rtl/param_cpu_core.sv
// Multi-cycle parameterised CPU core: fetch/execute controller, register file
// and a single request/ready memory port shared by fetches, loads and stores.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_execution,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_req,
  output logic              mem_write,
  output logic [DATA_W-1:0] alu_out,
  output logic [ADDR_W-1:0] pc,
  output logic              retired,
  output logic              halted
);

  state_t            state, state_next;
  logic [15:0]       instr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  opcode_t           op;
  logic [2:0]        rd_idx, rs_idx;
  logic [7:0]        imm;
  logic [3:0]        shamt;
  logic [DATA_W-1:0] rd_val, rs_val, alu_b, alu_result;
  logic [ADDR_W-1:0] branch_target, load_addr;

  function automatic logic [2:0] reg_index(input logic [2:0] field);
    return 3'(32'(field) % NUM_REGS);
  endfunction

  assign op     = opcode_t'(instr[OP_HI:OP_LO]);
  assign rd_idx = reg_index(instr[RD_HI:RD_LO]);
  assign rs_idx = reg_index(instr[RS_HI:RS_LO]);
  assign imm    = instr[IMM_HI:IMM_LO];
  assign shamt  = instr[SH_HI:SH_LO];
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];
  assign alu_b  = uses_imm(op) ? {{(DATA_W-8){1'b0}}, imm} : rs_val;

  // Branch offset is a 7-bit signed value subtracted from the current pc.
  assign branch_target = pc - ADDR_W'($signed(imm[6:0]));
  assign load_addr     = rs_val[ADDR_W-1:0] + ADDR_W'(shamt);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (rd_val),
    .b     (alu_b),
    .shift (shamt),
    .result(alu_result)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    retired    = 1'b0;
    case (state)
      S_FETCH:      if (start_execution) state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: if (mem_ready) state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (op == OP_HALT) begin
          state_next = S_HALT;
        end else if (is_alu_op(op)) begin
          state_next = S_WRITE_BACK;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          state_next = S_MEM_WAIT;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          state_next = S_FETCH;
          retired    = 1'b1;
        end else begin
          state_next = S_NEXT;
        end
      end
      S_WRITE_BACK: state_next = S_NEXT;
      S_MEM_WAIT:   if (mem_ready) state_next = S_NEXT;
      S_NEXT: begin
        state_next = S_FETCH;
        retired    = 1'b1;
      end
      S_HALT:       state_next = S_HALT;
      default:      state_next = S_FETCH;
    endcase
  end

  // Memory-port outputs are registered, so they stay put until the ready cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= '0;
      alu_out        <= '0;
      mem_req        <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      halted         <= 1'b0;
      instr          <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (start_execution) begin
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= pc;
          end
        end
        S_FETCH_WAIT: begin
          if (mem_ready) begin
            instr   <= mem_read_data[15:0];
            mem_req <= 1'b0;
          end
        end
        S_EXECUTE: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
          end else if (is_alu_op(op)) begin
            alu_out <= alu_result;
          end else if (is_single_op(op)) begin
            regs[rd_idx] <= alu_result;
          end else if (op == OP_BEQ) begin
            pc <= rd_val[0] ? branch_target : pc + 1'b1;
          end else if (op == OP_BNE) begin
            pc <= !rd_val[0] ? branch_target : pc + 1'b1;
          end else if (op == OP_LOAD) begin
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= load_addr;
          end else if (op == OP_STORE) begin
            mem_req        <= 1'b1;
            mem_write      <= 1'b1;
            mem_addr       <= rs_val[ADDR_W-1:0];
            mem_write_data <= rd_val;
          end
        end
        S_WRITE_BACK: regs[rd_idx] <= alu_out;
        S_MEM_WAIT: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            if (op == OP_LOAD) regs[rd_idx] <= mem_read_data;
          end
        end
        S_NEXT:  pc <= pc + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Scoreboard bench for param_cpu_core (DATA_W=32): directed programs push
// expected retire pcs and memory writes; a monitor pops and compares them.
module tb_param_cpu_core;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_execution = 1'b0;
  logic          mem_ready;
  logic [DW-1:0] mem_read_data = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_req, mem_write;
  logic [DW-1:0] alu_out;
  logic [AW-1:0] pc;
  logic          retired, halted;

  param_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_execution(start_execution),
    .mem_ready      (mem_ready),
    .mem_read_data  (mem_read_data),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_req        (mem_req),
    .mem_write      (mem_write),
    .alu_out        (alu_out),
    .pc             (pc),
    .retired        (retired),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [32];
  logic          resp_ready = 1'b0;
  logic          spurious_ready = 1'b0;
  logic          hold_writes = 1'b0;
  int            ready_delay = 0;
  int            wait_cnt = 0;

  assign mem_ready = resp_ready | spurious_ready;

  logic [31:0] retire_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          retire_cnt, max_wait, unstable, post_halt_req, req_wait;
  logic        req_active = 1'b0;
  logic [AW-1:0] req_addr;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] enc(input opcode_t op, input int rd, input logic [7:0] imm);
    return {16'h0, op, 3'(rd), imm};
  endfunction

  function automatic logic [7:0] rr(input int rs, input int sh);
    return {3'(rs), 4'(sh), 1'b0};
  endfunction

  task automatic apply_stimulus(input int addr, input logic [31:0] word);
    mem[addr] = word;
  endtask

  task automatic new_program();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    retire_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    retire_cnt = 0; max_wait = 0; unstable = 0; post_halt_req = 0;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_addr_q.push_back(addr);
    wr_data_q.push_back(data);
  endtask

  task automatic run_until_halt(input string name, input int budget);
    int n = 0;
    reset = 1'b1; start_execution = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0; start_execution = 1'b1;
    while (!halted && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_output({name, "_halt_reached"}, 32'(halted), 32'd1);
    repeat (4) @(negedge clock);
    #1;
    check_output({name, "_retire_left"}, 32'(retire_q.size()), 32'd0);
    check_output({name, "_write_left"}, 32'(wr_addr_q.size()), 32'd0);
    check_output({name, "_req_after_halt"}, 32'(post_halt_req), 32'd0);
  endtask

  // Memory responder: answers a request after ready_delay wait cycles.
  initial begin
    forever begin
      @(negedge clock);
      resp_ready = 1'b0;
      if (reset || !mem_req) begin
        wait_cnt = 0;
      end else if (!(mem_write && hold_writes)) begin
        if (wait_cnt < ready_delay) begin
          wait_cnt++;
        end else begin
          resp_ready = 1'b1;
          wait_cnt   = 0;
          if (mem_write) mem[mem_addr] = mem_write_data;
          else           mem_read_data = mem[mem_addr];
        end
      end
    end
  end

  // Monitor: pops the scoreboard on retire pulses and completed writes.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        req_active = 1'b0;
      end else begin
        if (retired) begin
          retire_cnt++;
          if (retire_q.size() == 0) check_output("unexpected_retire", 32'(pc), 32'hFFFF_FFFF);
          else check_output("retire_pc", 32'(pc), retire_q.pop_front());
        end
        if (mem_req && mem_write && mem_ready) begin
          if (wr_addr_q.size() == 0) begin
            check_output("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            check_output("write_addr", 32'(mem_addr), wr_addr_q.pop_front());
            check_output("write_data", mem_write_data, wr_data_q.pop_front());
          end
        end
        if (mem_req) begin
          if (!req_active) begin
            req_active = 1'b1;
            req_addr   = mem_addr;
            req_wait   = 0;
          end else if (mem_addr != req_addr) begin
            unstable++;
          end
          if (!mem_ready) req_wait++;
          else begin
            if (req_wait > max_wait) max_wait = req_wait;
            req_active = 1'b0;
          end
        end else begin
          req_active = 1'b0;
        end
        if (halted && mem_req) post_halt_req++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    new_program();
    // Reset state, and start_execution low holds the core in FETCH.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_output("rst_pc", 32'(pc), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_halted", 32'(halted), 32'd0);
    check_output("rst_alu_out", alu_out, 32'd0);
    check_output("rst_retired", 32'(retired), 32'd0);

    // LI r1,5; LI r2,3; ADD r1,r2; HALT
    new_program();
    apply_stimulus(0, enc(OP_LI, 1, 8'd5));
    apply_stimulus(1, enc(OP_LI, 2, 8'd3));
    apply_stimulus(2, enc(OP_ADD, 1, rr(2, 0)));
    apply_stimulus(3, enc(OP_HALT, 0, 8'd0));
    for (int i = 0; i < 3; i++) retire_q.push_back(i);
    run_until_halt("add", 300);
    check_output("add_pc", 32'(pc), 32'd3);
    check_output("add_alu_out", alu_out, 32'd8);
    check_output("add_retired", 32'(retire_cnt), 32'd3);

    // Every access delayed by four wait cycles.
    new_program();
    ready_delay = 4;
    apply_stimulus(0, enc(OP_LI, 1, 8'h5A));
    retire_q.push_back(0);
    run_until_halt("slow", 400);
    ready_delay = 0;
    check_output("slow_wait_cycles", 32'(max_wait), 32'd4);
    check_output("slow_addr_unstable", 32'(unstable), 32'd0);
    check_output("slow_retired", 32'(retire_cnt), 32'd1);
    check_output("slow_pc", 32'(pc), 32'd1);

    // 32-bit LUI / ADDI / SUB underflow, observed through stores to addr 20.
    new_program();
    apply_stimulus(0, enc(OP_LI, 7, 8'd20));
    apply_stimulus(1, enc(OP_LUI, 0, 8'hAB));
    apply_stimulus(2, enc(OP_STORE, 0, rr(7, 0)));
    apply_stimulus(3, enc(OP_ADDI, 0, 8'hFF));
    apply_stimulus(4, enc(OP_STORE, 0, rr(7, 0)));
    apply_stimulus(5, enc(OP_LI, 6, 8'd1));
    apply_stimulus(6, enc(OP_SUB, 1, rr(6, 0)));
    apply_stimulus(7, enc(OP_STORE, 1, rr(7, 0)));
    for (int i = 0; i < 8; i++) retire_q.push_back(i);
    expect_write(20, 32'hAB00_0000);
    expect_write(20, 32'hAB00_00FF);
    expect_write(20, 32'hFFFF_FFFF);
    run_until_halt("wide", 400);
    check_output("wide_pc", 32'(pc), 32'd8);
    check_output("wide_alu_out", alu_out, 32'hFFFF_FFFF);

    // COMP equal, then forward (-3) and backward (+2) taken branches.
    new_program();
    apply_stimulus(0, enc(OP_LI, 3, 8'd7));
    apply_stimulus(1, enc(OP_LI, 4, 8'd7));
    apply_stimulus(2, enc(OP_COMP, 3, rr(4, 0)));
    apply_stimulus(3, enc(OP_BEQ, 3, 8'h7D));
    apply_stimulus(6, enc(OP_BEQ, 3, 8'd2));
    retire_q = '{0, 1, 2, 3, 6};
    run_until_halt("beq", 300);
    check_output("beq_pc", 32'(pc), 32'd4);
    check_output("beq_comp", alu_out, 32'd1);

    // BNE not taken at pc 6 falls through to 7.
    new_program();
    apply_stimulus(0, enc(OP_LI, 3, 8'd1));
    apply_stimulus(1, enc(OP_BEQ, 3, 8'h7B));
    apply_stimulus(6, enc(OP_BNE, 3, 8'd2));
    retire_q = '{0, 1, 6};
    run_until_halt("bne", 300);
    check_output("bne_pc", 32'(pc), 32'd7);

    // STORE to 9, LOAD back via r0=5 + shift 4, store the loaded value, NOP.
    new_program();
    apply_stimulus(0, enc(OP_LI, 1, 8'h3C));
    apply_stimulus(1, enc(OP_LI, 5, 8'd9));
    apply_stimulus(2, enc(OP_STORE, 1, rr(5, 0)));
    apply_stimulus(3, enc(OP_LI, 0, 8'd5));
    apply_stimulus(4, enc(OP_LOAD, 2, rr(0, 4)));
    apply_stimulus(5, enc(OP_LI, 6, 8'd12));
    apply_stimulus(6, enc(OP_STORE, 2, rr(6, 0)));
    apply_stimulus(7, {16'h0, 5'd31, 11'h7FF});
    for (int i = 0; i < 8; i++) retire_q.push_back(i);
    expect_write(9, 32'h3C);
    expect_write(12, 32'h3C);
    run_until_halt("ldst", 400);
    check_output("ldst_pc", 32'(pc), 32'd8);

    // Reset while a store is stuck in MEM_WAIT, then a stray mem_ready.
    new_program();
    apply_stimulus(0, enc(OP_LI, 5, 8'd9));
    apply_stimulus(1, enc(OP_STORE, 5, rr(5, 0)));
    retire_q.push_back(0);
    hold_writes = 1'b1;
    reset = 1'b1; start_execution = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0; start_execution = 1'b1;
    for (int n = 0; n < 100 && !mem_write; n++) @(negedge clock);
    check_output("mw_reached", 32'(mem_write), 32'd1);
    reset = 1'b1; start_execution = 1'b0;
    @(negedge clock);
    #1;
    check_output("mw_rst_req", 32'(mem_req), 32'd0);
    check_output("mw_rst_write", 32'(mem_write), 32'd0);
    check_output("mw_rst_addr", 32'(mem_addr), 32'd0);
    check_output("mw_rst_wdata", mem_write_data, 32'd0);
    check_output("mw_rst_pc", 32'(pc), 32'd0);
    check_output("mw_rst_retired", 32'(retired), 32'd0);
    check_output("mw_rst_halted", 32'(halted), 32'd0);
    @(negedge clock);
    reset = 1'b0; hold_writes = 1'b0;
    spurious_ready = 1'b1;
    @(negedge clock);
    spurious_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_output("late_ready_pc", 32'(pc), 32'd0);
    check_output("late_ready_req", 32'(mem_req), 32'd0);
    check_output("mw_retire_left", 32'(retire_q.size()), 32'd0);
    check_output("mw_retired", 32'(retire_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
